// File: rtl/ifetch_rv32i_if.sv
// Fetch-stage bundle: instruction-memory request/ack, PC redirect and decode valid/ready.
// The master modport is the fetch unit; the slave modport is memory, branch unit and decoder.
interface ifetch_rv32i_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [24:0] dec_trimmed_instr;
    logic        fault_misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr, dec_pc, dec_opcode, dec_trimmed_instr, fault_misaligned
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr, dec_pc, dec_opcode, dec_trimmed_instr, fault_misaligned
    );
endinterface

// File: rtl/ifetch_rv32i.sv
// RV32I instruction fetch: owns the PC, fetches over req/ack, and holds one instruction for decode.
// Handles branch/jump redirects, including ones that land while a memory request is in flight.
module ifetch_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    ifetch_rv32i_if.master bus
);
    typedef enum logic [2:0] {StIdle, StReq, StHold, StFlush, StFault} state_e;

    localparam logic [31:0] Nop = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        redir_bad;
    logic        redir_ok;

    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_ok  = bus.redirect_valid && !redir_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            instr_q  <= Nop;
            ipc_q    <= RESET_PC;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        fault_d  = fault_q;

        // A misaligned target locks the stage up from any live state; only reset recovers.
        if (state_q != StFault && redir_bad) begin
            state_d = StFault;
            fault_d = 1'b1;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redir_ok) pc_d = bus.redirect_pc;
                    state_d = StReq;
                end
                StReq: begin
                    if (redir_ok) begin
                        if (bus.imem_ack) begin
                            pc_d = bus.redirect_pc;
                        end else begin
                            // Address must stay put until the in-flight request is acked.
                            target_d = bus.redirect_pc;
                            state_d  = StFlush;
                        end
                    end else if (bus.imem_ack) begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (redir_ok) begin
                        valid_d = 1'b0;
                        pc_d    = bus.redirect_pc;
                        state_d = StReq;
                    end else if (bus.dec_ready) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + 32'd4;
                        state_d = StReq;
                    end
                end
                StFlush: begin
                    if (bus.imem_ack) begin
                        pc_d    = redir_ok ? bus.redirect_pc : target_q;
                        state_d = StReq;
                    end else if (redir_ok) begin
                        target_d = bus.redirect_pc;
                    end
                end
                StFault: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = StFault;
                end
            endcase
        end
    end

    assign bus.imem_req          = (state_q == StReq) || (state_q == StFlush);
    assign bus.imem_addr         = pc_q;
    assign bus.dec_valid         = valid_q;
    assign bus.dec_instr         = instr_q;
    assign bus.dec_pc            = ipc_q;
    assign bus.dec_opcode        = instr_q[6:0];
    assign bus.dec_trimmed_instr = instr_q[31:7];
    assign bus.fault_misaligned  = fault_q;
endmodule

// File: tb/tb_ifetch_rv32i.sv
// Self-checking bench for ifetch_rv32i: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage (pending fetch, held instruction, discard, fault).
module tb_ifetch_rv32i;
    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_rv32i_if bus();

    ifetch_rv32i #(.RESET_PC(RstPc)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: "started" is false only in the cycle right after reset, "hold" means an
    // instruction waits for decode, "discard" means the outstanding response is stale.
    bit          m_fault, m_started, m_hold, m_discard;
    logic [31:0] m_pc, m_target, m_instr, m_ipc;
    logic [31:0] last_ack_data;

    function automatic logic m_req();
        return !m_fault && m_started && !m_hold;
    endfunction

    task automatic model_reset();
        m_fault = 0; m_started = 0; m_hold = 0; m_discard = 0;
        m_pc = RstPc; m_target = 0; m_instr = 32'h0000_0013; m_ipc = RstPc;
    endtask

    task automatic model_step(input logic ack, input logic rv, input logic [31:0] rpc,
                              input logic ready, input logic [31:0] rdata);
        if (m_fault) return;
        if (rv && rpc[1:0] != 2'b00) begin
            m_fault = 1; m_hold = 0;
        end else if (!m_started) begin
            m_started = 1;
            if (rv) m_pc = rpc;
        end else if (m_hold) begin
            if (rv) begin m_hold = 0; m_pc = rpc; end
            else if (ready) begin m_hold = 0; m_pc = m_pc + 32'd4; end
        end else if (ack) begin
            if (rv || m_discard) begin
                m_pc = rv ? rpc : m_target;
                m_discard = 0;
            end else begin
                m_hold = 1; m_instr = rdata; m_ipc = m_pc;
            end
        end else if (rv) begin
            m_discard = 1; m_target = rpc;
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic cycle(input logic ack_en, input logic rv, input logic [31:0] rpc,
                         input logic ready);
        logic        ack;
        logic [31:0] rdata;
        ack   = ack_en && m_req();
        rdata = $urandom;
        bus.imem_ack = ack; bus.imem_rdata = rdata;
        bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.dec_ready = ready;
        @(posedge clk);
        model_step(ack, rv, rpc, ready, rdata);
        if (ack) last_ack_data = rdata;
        @(negedge clk);
        bus.imem_ack = 1'b0; bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        bus.imem_ack = 0; bus.imem_rdata = 0; bus.redirect_valid = 0;
        bus.redirect_pc = 0; bus.dec_ready = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++;
            $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.dec_instr !== 32'h0000_0013) begin n_fail++;
            $display("FAIL reset_instr: got %h want 00000013", bus.dec_instr); end
        n_checks++; if (bus.dec_opcode !== 7'h13) begin n_fail++;
            $display("FAIL reset_opcode: got %h want 13", bus.dec_opcode); end
        n_checks++; if (bus.dec_pc !== RstPc) begin n_fail++;
            $display("FAIL reset_pc: got %h want %h", bus.dec_pc, RstPc); end
        n_checks++; if (bus.fault_misaligned !== 1'b0) begin n_fail++;
            $display("FAIL reset_fault: got %b want 0", bus.fault_misaligned); end
    endtask

    task automatic test_sequential();
        int nreq = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            // Requests alternate with hold cycles: req on even i, valid on odd i.
            n_checks++; if (bus.imem_req !== (i % 2 == 0)) begin n_fail++;
                $display("FAIL seq_req_%0d: got %b want %b", i, bus.imem_req, (i % 2 == 0)); end
            if (i % 2 == 0) begin
                n_checks++; if (bus.imem_addr !== RstPc + 32'(4 * nreq)) begin n_fail++;
                    $display("FAIL seq_addr_%0d: got %h want %h", i, bus.imem_addr,
                             RstPc + 32'(4 * nreq)); end
                nreq++;
            end else begin
                n_checks++; if (bus.dec_pc !== RstPc + 32'(4 * (nreq - 1))) begin n_fail++;
                    $display("FAIL seq_dec_pc_%0d: got %h want %h", i, bus.dec_pc,
                             RstPc + 32'(4 * (nreq - 1))); end
                n_checks++; if (bus.dec_trimmed_instr !== last_ack_data[31:7]) begin n_fail++;
                    $display("FAIL seq_trimmed_%0d: got %h want %h", i, bus.dec_trimmed_instr,
                             last_ack_data[31:7]); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RstPc) begin n_fail++;
                $display("FAIL stall_req_%0d: got %b/%h want 1/%h", i, bus.imem_req,
                         bus.imem_addr, RstPc); end
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_instr !== last_ack_data ||
                            bus.dec_pc !== RstPc) begin n_fail++;
                $display("FAIL stall_hold_%0d: got %b/%h/%h want 1/%h/%h", i, bus.dec_valid,
                         bus.dec_instr, bus.dec_pc, last_ack_data, RstPc); end
            n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++;
                $display("FAIL stall_noreq_%0d: got %b want 0", i, bus.imem_req); end
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RstPc + 32'd4) begin n_fail++;
            $display("FAIL stall_next: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr,
                     RstPc + 32'd4); end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin n_fail++;
            $display("FAIL flush_hold_addr: got %b/%h want 1/104", bus.imem_req,
                     bus.imem_addr); end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (bus.imem_addr !== 32'h104) begin n_fail++;
            $display("FAIL flush_hold_addr2: got %h want 104", bus.imem_addr); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_discard: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++;
            $display("FAIL flush_target: got %b/%h want 1/200", bus.imem_req, bus.imem_addr); end
        // Second flush where the latest redirect wins.
        cycle(1'b0, 1'b1, 32'h250, 1'b0);
        cycle(1'b0, 1'b1, 32'h300, 1'b0);
        n_checks++; if (bus.imem_addr !== 32'h200) begin n_fail++;
            $display("FAIL flush2_hold_addr: got %h want 200", bus.imem_addr); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++; if (bus.imem_addr !== 32'h300 || bus.dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush2_target: got %h/%b want 300/0", bus.imem_addr, bus.dec_valid); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h300) begin n_fail++;
            $display("FAIL flush2_deliver: got %b/%h want 1/300", bus.dec_valid, bus.dec_pc); end
    endtask

    task automatic test_hold_redirect();
        cycle(1'b0, 1'b1, 32'h400, 1'b1);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL holdredir_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin n_fail++;
            $display("FAIL holdredir_req: got %b/%h want 1/400", bus.imem_req, bus.imem_addr); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h400) begin n_fail++;
            $display("FAIL holdredir_next: got %b/%h want 1/400", bus.dec_valid, bus.dec_pc); end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++;
            $display("FAIL wrap_top: got %h want fffffffc", bus.imem_addr); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL wrap_zero: got %b/%h want 1/00000000", bus.imem_req,
                     bus.imem_addr); end
    endtask

    task automatic test_misaligned();
        cycle(1'b0, 1'b1, 32'h402, 1'b0);
        n_checks++; if (bus.fault_misaligned !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++;
            $display("FAIL misal_flag: got %b/%b want 1/0", bus.fault_misaligned,
                     bus.imem_req); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, 1'b1);
            n_checks++; if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0 ||
                            bus.fault_misaligned !== 1'b1) begin n_fail++;
                $display("FAIL misal_stuck_%0d: got req %b valid %b fault %b want 0/0/1", i,
                         bus.imem_req, bus.dec_valid, bus.fault_misaligned); end
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (bus.fault_misaligned !== 1'b0 || bus.dec_instr !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL misal_async_reset: got %b/%h want 0/00000013",
                     bus.fault_misaligned, bus.dec_instr); end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RstPc) begin n_fail++;
            $display("FAIL misal_restart: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr,
                     RstPc); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), rpc,
                  ($urandom_range(0, 2) != 0));
            n_checks++; if (bus.imem_req !== m_req()) begin n_fail++;
                $display("FAIL rnd_req_%0d: got %b want %b", i, bus.imem_req, m_req()); end
            if (m_req()) begin
                n_checks++; if (bus.imem_addr !== m_pc) begin n_fail++;
                    $display("FAIL rnd_addr_%0d: got %h want %h", i, bus.imem_addr, m_pc); end
            end
            n_checks++; if (bus.dec_valid !== m_hold) begin n_fail++;
                $display("FAIL rnd_valid_%0d: got %b want %b", i, bus.dec_valid, m_hold); end
            n_checks++; if (bus.dec_instr !== m_instr || bus.dec_pc !== m_ipc) begin n_fail++;
                $display("FAIL rnd_out_%0d: got %h@%h want %h@%h", i, bus.dec_instr,
                         bus.dec_pc, m_instr, m_ipc); end
            n_checks++; if (bus.dec_opcode !== m_instr[6:0] ||
                            bus.dec_trimmed_instr !== m_instr[31:7]) begin n_fail++;
                $display("FAIL rnd_slices_%0d: got %h/%h want %h/%h", i, bus.dec_opcode,
                         bus.dec_trimmed_instr, m_instr[6:0], m_instr[31:7]); end
            n_checks++; if (bus.fault_misaligned !== m_fault) begin n_fail++;
                $display("FAIL rnd_fault_%0d: got %b want %b", i, bus.fault_misaligned,
                         m_fault); end
            if (m_fault && $urandom_range(0, 7) == 0) do_reset();
        end
    endtask

    initial begin
        model_reset();
        last_ack_data = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_hold_redirect();
        test_wrap();
        test_misaligned();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
